// File: rtl/fifo_mem_ctrl_pkg.sv
// Shared constants, pointer-flag bundle and flag helper for the FIFO controller.
// Default widths used by fifo_mem_ctrl and its pointer sub-module.
package fifo_mem_ctrl_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int PTR_W  = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic full;
        logic empty;
    } ptr_flags_t;

    // Pointers carry one wrap bit above the address bits.
    // Full means only that wrap bit differs.
    function automatic ptr_flags_t ptr_flags(
        input logic [31:0] wp,
        input logic [31:0] rp,
        input int          aw
    );
        ptr_flags_t  f;
        logic [31:0] x;
        x       = wp ^ rp;
        f.empty = (x == 32'd0);
        f.full  = (x == (32'd1 << aw));
        return f;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter with increment and synchronous clear.
// Ports: clk, rst_n, clr (sync clear), inc (advance by one), ptr (current value).
module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_mem_ctrl.sv
// FIFO controller sequencing an external 1-cycle simple-dual-port RAM.
// Ports: push/pop side, status (full/empty/almost/count), sticky errors, RAM ctrl.
module fifo_mem_ctrl
    import fifo_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int AF_TH      = 14,
    parameter int AE_TH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int P_W = ADDR_WIDTH + 1;
    localparam logic [P_W-1:0] AF_C = P_W'(AF_TH);
    localparam logic [P_W-1:0] AE_C = P_W'(AE_TH);

    logic [P_W-1:0] wr_ptr;
    logic [P_W-1:0] rd_ptr;
    ptr_flags_t     fl;
    logic           push_acc;
    logic           pop_acc;

    logic [P_W-1:0] count_q, count_d;
    logic           af_q, af_d;
    logic           ae_q, ae_d;
    logic           pv_q, pv_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;

    // Flags follow the registered pointers, so they reflect the last edge.
    assign fl    = ptr_flags(32'(wr_ptr), 32'(rd_ptr), ADDR_WIDTH);
    assign full  = fl.full;
    assign empty = fl.empty;

    assign push_acc = push & ~fl.full & ~flush;
    assign pop_acc  = pop & ~fl.empty & ~flush;

    fifo_ptr #(.W(P_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(P_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop_acc),
        .ptr   (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            flush:                count_d = '0;
            push_acc & ~pop_acc:  count_d = count_q + P_W'(1);
            pop_acc & ~push_acc:  count_d = count_q - P_W'(1);
            default:              count_d = count_q;
        endcase
        af_d = (count_d >= AF_C);
        ae_d = (count_d <= AE_C);
        pv_d = pop_acc;
        // Clear first so a same-cycle error still sets the flag.
        ovf_d = clr_err ? 1'b0 : ovf_q;
        unf_d = clr_err ? 1'b0 : unf_q;
        if (push & fl.full & ~flush) begin
            ovf_d = 1'b1;
        end
        if (pop & fl.empty & ~flush) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            pv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            pv_q    <= pv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count        = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign pop_valid    = pv_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign pop_data     = mem_dout;

    assign mem_wr_en   = push_acc;
    assign mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign mem_din     = push_data;
    assign mem_rd_en   = pop_acc;
    assign mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

endmodule
